obc_dft_shift_accumulator: RTL and testbench
============================================

// Module: obc_dft_shift_accumulator
// PURPOSE
//  Bit-serial controller/accumulator for one OBC distributed-arithmetic DFT bin output (real or imag).
//  Loads 16 input samples, emits one bit-slice per cycle LSB-first with the MSB flag m, and
//  shift-accumulates the per-slice 32-bit partial sum returned by the bin's ROM combiner.
//  The ROM combiner is combinational and returns its partial sum in the same cycle.
//  Applies the OBC offset and the final /2 scaling, then presents the bin result with a done pulse.
//  Sits directly downstream of the per-bin ROM combiner: it drives the combiner's slice/m inputs
//  and consumes its romout.
// PARAMETERS
//  DW      16   sample width = number of bit-serial cycles per transform
//  RW      32   width of romout partial sum (signed two's complement)
//  AW      48   accumulator/result width, must be >= RW+DW
//  OFFSET  0    signed AW-bit OBC offset constant for this bin, added once before scaling
// PORTS
//  clk      in   1       single clock, all state on rising edge
//  rst      in   1       synchronous, active-high reset
//  start    in   1       begin transform; accepted only in IDLE
//  x_in     in   16*DW   samples, sample n = x_in[n*DW +: DW], two's complement
//  busy     out  1       high in RUN and FINISH
//  slice    out  16      slice[n] = bit k of sample n in the current RUN cycle; drives x0n of combiner
//  m        out  1       high on the MSB slice cycle (k==DW-1); drives combiner m
//  romout   in   RW      signed partial sum from combiner for the current slice
//  done     out  1       one-cycle pulse when result updates
//  result   out  AW      signed bin result, held until next done or reset
// BEHAVIOUR
//  - Reset: state=IDLE, k=0, acc=0, busy=0, slice=0, m=0, done=0, result=0. Reset mid-transform aborts
//    immediately; no done pulse is produced for the aborted transform.
//  - FSM IDLE->RUN->FINISH->IDLE.
//    IDLE: slice=0, m=0. On start, capture x_in into the slice registers, set k=0, acc=0, go to RUN.
//    RUN, one cycle per k = 0..DW-1: slice = bit k of each captured sample; m=(k==DW-1);
//      acc <= acc + (sext_AW(romout) <<< k). After k==DW-1, go to FINISH.
//    FINISH: result <= (acc + OFFSET) >>> 1 (arithmetic shift); done=1 for this cycle only; go to IDLE.
//  - Timing: start sampled at edge 0, RUN occupies edges 1..DW, FINISH at edge DW+1.
//    done and the new result are visible after edge DW+1: DW+1 cycles of latency (17 at default).
//  - start while busy (RUN or FINISH) is ignored; no queueing. Earliest restart is the cycle after FINISH.
//  - x_in may change after capture with no effect. romout is sampled only in RUN.
//  - All arithmetic is signed AW-bit and wraps modulo 2^AW. With AW >= RW+DW no overflow occurs.
//  - MSB negation is done by the combiner through m. The accumulator never negates.
// STRUCTURE
//  - Package obc_dft_pkg: DW, RW, AW defaults; state enum {IDLE,RUN,FINISH};
//    per-bin OFFSET constants (real/imag, bins 0..15).
//  - One sub-module obc_bit_slicer: 16 parallel DW-bit shift registers with load/shift enable,
//    outputting the 16-bit LSB slice.
//  - FSM, bit counter, accumulator and result register live in the top module.
// TESTING
//  1 Stub romout=1 every RUN cycle, OFFSET=0, start once
//    -> done exactly once, DW+1 cycles after start; result=32767 (acc=65535).
//  2 Stub romout=32'hFFFFFFFF (-1) -> acc=-65535, result=-32768 (48'hFFFF_FFFF_8000).
//  3 Sample n = 1<<n (n=0..15) -> in RUN cycle k, slice is one-hot at bit k;
//    m=1 only at k=15; slice=0 and m=0 in IDLE.
//  4 Second start pulse 3 cycles after the first
//    -> ignored; single done at cycle 17; busy stays high for cycles 1..17.
//  5 rst asserted in RUN at k=5 -> next cycle busy=0, result=0, no done;
//    a fresh start then completes normally with the expected result.
//  6 Hook up the real bin-10 imag combiner, samples x[n]=n*256
//    -> result matches the golden model's bin-10 imag value (OBC, same OFFSET) bit-exactly.

Source files
------------

// File: rtl/obc_dft_shift_accumulator_pkg.sv
// Shared constants, FSM encoding and per-bin OBC offsets for the DA DFT bins.
// Offsets are -sum of the 4096-scaled bin coefficients; only the real DC bin is non-zero.
package obc_dft_pkg;

  localparam int unsigned N_PTS = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned RW    = 32;
  localparam int unsigned AW    = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic signed [AW-1:0] OFFSET_RE [N_PTS] = '{0: -48'sd65536, default: 48'sd0};
  localparam logic signed [AW-1:0] OFFSET_IM [N_PTS] = '{default: 48'sd0};

endpackage

// File: rtl/obc_dft_shift_accumulator_if.sv
// Sample/result handshake plus the slice/m/romout link to the per-bin ROM combiner.
interface obc_dft_shift_accumulator_if #(
  parameter int unsigned DW = obc_dft_pkg::DW,
  parameter int unsigned RW = obc_dft_pkg::RW,
  parameter int unsigned AW = obc_dft_pkg::AW,
  parameter int unsigned N  = obc_dft_pkg::N_PTS
);

  logic                 start;
  logic [N*DW-1:0]      x_in;
  logic                 busy;
  logic [N-1:0]         slice;
  logic                 m;
  logic signed [RW-1:0] romout;
  logic                 done;
  logic signed [AW-1:0] result;

  modport master (
    output start, x_in, romout,
    input  busy, slice, m, done, result
  );

  modport slave (
    input  start, x_in, romout,
    output busy, slice, m, done, result
  );

endinterface

// File: rtl/obc_bit_slicer.sv
// N parallel DW-bit shift registers; slice[n] is the current LSB of sample n.
module obc_bit_slicer #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [N*DW-1:0] x_in,
  output logic [N-1:0]    slice
);

  logic [DW-1:0] sr_q [N];

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < N; n++) begin
      if (rst) begin
        sr_q[n] <= '0;
      end else if (load) begin
        sr_q[n] <= x_in[n*DW +: DW];
      end else if (shift) begin
        sr_q[n] <= sr_q[n] >> 1;
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int unsigned n = 0; n < N; n++) begin
      slice[n] = sr_q[n][0];
    end
  end

endmodule

// File: rtl/obc_dft_shift_accumulator.sv
// Bit-serial OBC DA controller: drives the combiner LSB-first, shift-accumulates
// its partial sums, then applies the bin offset and the final /2 scaling.
module obc_dft_shift_accumulator #(
  parameter int unsigned          DW     = obc_dft_pkg::DW,
  parameter int unsigned          RW     = obc_dft_pkg::RW,
  parameter int unsigned          AW     = obc_dft_pkg::AW,
  parameter logic signed [AW-1:0] OFFSET = '0
) (
  input logic                         clk,
  input logic                         rst,
  obc_dft_shift_accumulator_if.slave  bus
);

  import obc_dft_pkg::*;

  localparam int unsigned     KW     = $clog2(DW);
  localparam logic [KW-1:0]   K_LAST = KW'(DW - 1);

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] result_q;
  logic                 done_q;
  logic signed [AW-1:0] rom_ext;
  logic signed [AW-1:0] offset_sum;
  logic                 load, shift, busy_c, m_c;
  logic [N_PTS-1:0]     slice_raw;

  obc_bit_slicer #(
    .DW (DW),
    .N  (N_PTS)
  ) u_slicer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .x_in  (bus.x_in),
    .slice (slice_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = (state_q == IDLE) && bus.start;
    shift  = (state_q == RUN);
    busy_c = (state_q != IDLE);
    m_c    = (state_q == RUN) && (k_q == K_LAST);
  end

  assign rom_ext    = {{(AW-RW){bus.romout[RW-1]}}, bus.romout};
  assign offset_sum = acc_q + OFFSET;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_q + (rom_ext <<< k_q);
          k_q   <= k_q + 1'b1;
        end
        FINISH: begin
          result_q <= offset_sum >>> 1;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.m      = m_c;
  assign bus.slice  = shift ? slice_raw : '0;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_obc_dft_shift_accumulator.sv
// Directed bench: stubbed and modelled combiner, hand-computed bin results.
module tb_obc_dft_shift_accumulator;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 32;
  localparam int unsigned AW = 48;

  // bin-10 imag coefficients, round(-4096*sin(2*pi*10*n/16))
  localparam int COEF [16] = '{0, 2896, -4096, 2896, 0, -2896, 4096, -2896,
                               0, 2896, -4096, 2896, 0, -2896, 4096, -2896};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rom_mode = 2'd0;
  int checks = 0;
  int passed = 0;

  obc_dft_shift_accumulator_if #(.DW(DW), .RW(RW), .AW(AW)) bus ();

  obc_dft_shift_accumulator #(
    .DW     (DW),
    .RW     (RW),
    .AW     (AW),
    .OFFSET (obc_dft_pkg::OFFSET_IM[10])
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] combiner(input logic [15:0] s, input logic mm);
    int sum;
    sum = 0;
    for (int n = 0; n < 16; n++) sum += s[n] ? COEF[n] : -COEF[n];
    return mm ? -sum : sum;
  endfunction

  always_comb begin
    case (rom_mode)
      2'd0:    bus.romout = 32'sd1;
      2'd1:    bus.romout = -32'sd1;
      default: bus.romout = combiner(bus.slice, bus.m);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [16*DW-1:0] x);
    bus.x_in  = x;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to_done(input string name, input logic [AW-1:0] expv);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus.done) got = 1'b1;
    end
    checks++;
    if (!got) $display("FAIL %s_timeout: done=0 required done=1 within 40 cycles", name);
    else passed++;
    checks++;
    if (bus.result !== expv) $display("FAIL %s_result: got %h required %h", name, bus.result, expv);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.m} !== 3'b000) $display("FAIL reset_ctrl: busy/done/m=%b required 000", {bus.busy, bus.done, bus.m});
    else passed++;
    checks++;
    if (bus.slice !== 16'h0) $display("FAIL reset_slice: got %h required 0000", bus.slice);
    else passed++;
    checks++;
    if (bus.result !== 48'h0) $display("FAIL reset_result: got %h required 0", bus.result);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_const_one();
    int dones, done_edge;
    dones = 0;
    done_edge = -1;
    rom_mode = 2'd0;
    do_start({16{16'h1234}});
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (bus.done) begin
        dones++;
        done_edge = e;
      end
    end
    checks++;
    if (dones !== 1) $display("FAIL one_done_count: got %0d required 1", dones);
    else passed++;
    checks++;
    if (done_edge !== 17) $display("FAIL one_latency: got %0d required 17", done_edge);
    else passed++;
    checks++;
    if (bus.result !== 48'd32767) $display("FAIL one_result: got %h required %h", bus.result, 48'd32767);
    else passed++;
  endtask

  task automatic test_const_neg();
    rom_mode = 2'd1;
    do_start({16{16'hA5A5}});
    run_to_done("neg", 48'hFFFF_FFFF_8000);
  endtask

  task automatic test_slice_pattern();
    logic [16*DW-1:0] x;
    for (int n = 0; n < 16; n++) x[n*DW +: DW] = 16'(1 << n);
    rom_mode = 2'd0;
    checks++;
    if ({bus.slice, bus.m} !== 17'h0) $display("FAIL idle_slice: slice=%h m=%b required 0/0", bus.slice, bus.m);
    else passed++;
    do_start(x);
    bus.x_in = '1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.slice !== 16'(1 << k)) $display("FAIL slice_k%0d: got %h required %h", k, bus.slice, 16'(1 << k));
      else passed++;
      checks++;
      if (bus.m !== (k == 15)) $display("FAIL m_k%0d: got %b required %b", k, bus.m, (k == 15));
      else passed++;
      tick();
    end
    tick();
    checks++;
    if ({bus.slice, bus.m} !== 17'h0) $display("FAIL post_slice: slice=%h m=%b required 0/0", bus.slice, bus.m);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int dones, busy_err;
    dones = 0;
    busy_err = 0;
    rom_mode = 2'd0;
    tick();
    do_start({16{16'h0F0F}});
    for (int e = 1; e <= 40; e++) begin
      bus.start = (e == 3);
      tick();
      bus.start = 1'b0;
      if (bus.done) dones++;
      if (bus.busy !== (e <= 16)) busy_err++;
      if (e == 17) begin
        checks++;
        if (bus.done !== 1'b1) $display("FAIL ign_done_edge: got %b required 1 at cycle 17", bus.done);
        else passed++;
      end
    end
    checks++;
    if (busy_err !== 0) $display("FAIL ign_busy: %0d busy errors required 0", busy_err);
    else passed++;
    checks++;
    if (dones !== 1) $display("FAIL ign_done_count: got %0d required 1", dones);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    rom_mode = 2'd0;
    do_start({16{16'h7777}});
    for (int e = 1; e <= 5; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b required 0", bus.busy);
    else passed++;
    checks++;
    if (bus.result !== 48'h0) $display("FAIL rstmid_result: got %h required 0", bus.result);
    else passed++;
    for (int e = 0; e < 25; e++) begin
      if (bus.done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) $display("FAIL rstmid_no_done: got %0d dones required 0", dones);
    else passed++;
    do_start({16{16'h1111}});
    run_to_done("rstmid_restart", 48'd32767);
  endtask

  task automatic test_bin10_imag();
    logic [16*DW-1:0] x;
    logic signed [AW-1:0] expv;
    for (int n = 0; n < 16; n++) x[n*DW +: DW] = 16'(n * 256);
    expv = -48'sd3473408;
    rom_mode = 2'd2;
    tick();
    do_start(x);
    run_to_done("bin10_imag", expv);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x_in  = '0;
    test_reset();
    test_const_one();
    test_const_neg();
    test_slice_pattern();
    test_start_ignored();
    test_reset_mid();
    test_bin10_imag();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
